// File: rtl/jk_bank_seq.sv
// jk_bank_seq: command sequencer that drives the J/K inputs of an external
// bank of JK flip-flops. LOAD, UP, DOWN and TOGGLE commands become per-bit
// J/K vectors. The bank's Q outputs are fed back to form the count carries.
module jk_bank_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_arg_i,
  input  logic [CNT_W-1:0] cmd_len_i,
  input  logic [WIDTH-1:0] q_in_i,
  output logic [WIDTH-1:0] j_out_o,
  output logic [WIDTH-1:0] k_out_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_UP     = 2'b01;
  localparam logic [1:0] OP_DOWN   = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] rem_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] arg_q;

  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_dn;

  // Command acceptance, step counting and state sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      op_q    <= OP_LOAD;
      arg_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            op_q  <= cmd_op_i;
            arg_q <= cmd_arg_i;
            if (cmd_op_i == OP_LOAD) begin
              rem_q   <= CNT_ONE;
              state_q <= S_RUN;
            end else begin
              rem_q   <= cmd_len_i;
              state_q <= (cmd_len_i == '0) ? S_DONE : S_RUN;
            end
          end
        end
        S_RUN: begin
          // rem_q is never zero here: a zero-length command skips RUN
          rem_q <= rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Carry/borrow chains: bit i toggles when every lower bit is 1 (up) or 0 (down)
  always_comb begin
    t_up    = '0;
    t_dn    = '0;
    t_up[0] = 1'b1;
    t_dn[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      t_up[i] = t_up[i-1] & q_in_i[i-1];
      t_dn[i] = t_dn[i-1] & ~q_in_i[i-1];
    end
  end

  // J/K drive: the bank holds (J=K=0) unless a command is running
  always_comb begin
    j_out_o = '0;
    k_out_o = '0;
    if (state_q == S_RUN) begin
      case (op_q)
        OP_LOAD:   begin j_out_o = arg_q; k_out_o = ~arg_q; end
        OP_UP:     begin j_out_o = t_up;  k_out_o = t_up;   end
        OP_DOWN:   begin j_out_o = t_dn;  k_out_o = t_dn;   end
        OP_TOGGLE: begin j_out_o = arg_q; k_out_o = arg_q;  end
        default:   begin j_out_o = '0;    k_out_o = '0;     end
      endcase
    end
  end

  // Status outputs decode the registered state. Ready is masked during reset.
  assign cmd_ready_o = (state_q == S_IDLE) && !reset;
  assign busy_o      = (state_q == S_RUN) || (state_q == S_DONE);
  assign done_o      = (state_q == S_DONE);

endmodule
